// File: rtl/mac_drain_if.sv
// Output stream of the MAC drain stage: one requantized element per valid/ready handshake.
interface mac_drain_if #(
    parameter int OUTPUT_DATA_WIDTH = 4
);
    logic [OUTPUT_DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/mac_drain.sv
// Snapshots all MAC accumulators on start, then streams them out one per handshake,
// each requantized by a rounding right-shift with unsigned saturation.
module mac_drain #(
    parameter int NUM_MACS               = 4,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int OUTPUT_DATA_WIDTH      = 4,
    parameter int SHIFT_WIDTH            = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [NUM_MACS*ACCUMULATOR_DATA_WIDTH-1:0] acc_in,
    input  logic [SHIFT_WIDTH-1:0]                   shift,
    mac_drain_if.master                              out_if,
    output logic                                     busy,
    output logic                                     done
);
    localparam int ACC   = ACCUMULATOR_DATA_WIDTH;
    localparam int OUTW  = OUTPUT_DATA_WIDTH;
    localparam int IDX_W = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [ACC:0] ONE_W   = {{ACC{1'b0}}, 1'b1};
    localparam logic [ACC:0] SAT_MAX = {{(ACC+1-OUTW){1'b0}}, {OUTW{1'b1}}};

    logic [0:0]             r_state;
    logic [IDX_W-1:0]       r_index;
    logic [SHIFT_WIDTH-1:0] r_shift;
    logic [ACC-1:0]         r_bank [NUM_MACS];
    logic                   r_done;

    logic            w_send;
    logic            w_last;
    logic            w_xfer;
    logic [OUTW-1:0] w_out_data;

    // One extra bit of headroom keeps acc + half-LSB from wrapping; shifts past ACC give 0.
    function automatic logic [OUTW-1:0] requant(input logic [ACC-1:0] acc,
                                                 input logic [SHIFT_WIDTH-1:0] s);
        logic [ACC:0] wide;
        logic [ACC:0] r;
        wide = {1'b0, acc};
        if (s == '0) begin
            r = wide;
        end else begin
            r = (wide + (ONE_W << (s - 1'b1))) >> s;
        end
        return (r > SAT_MAX) ? SAT_MAX[OUTW-1:0] : r[OUTW-1:0];
    endfunction

    assign w_send     = (r_state == ST_SEND);
    assign w_last     = w_send && (r_index == IDX_W'(NUM_MACS - 1));
    assign w_xfer     = w_send && out_if.out_ready;
    assign w_out_data = requant(r_bank[r_index], r_shift);

    assign out_if.out_data  = w_out_data;
    assign out_if.out_valid = w_send;
    assign out_if.out_last  = w_last;
    assign busy             = w_send;
    assign done             = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            // NOTE: the capture bank is reset on purpose so out_data reads 0 after reset.
            for (int i = 0; i < NUM_MACS; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_MACS; i++) begin
                            r_bank[i] <= acc_in[i*ACC +: ACC];
                        end
                        r_shift <= shift;
                        r_index <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_index <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_drain.sv
// Randomized scoreboard bench for mac_drain: stimulus pushes expected elements, a negedge monitor checks them.
module tb_mac_drain;
    localparam int N    = 4;
    localparam int ACC  = 16;
    localparam int OW   = 4;
    localparam int SW   = 4;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [N*ACC-1:0]  acc_in = '0;
    logic [SW-1:0]     shift = '0;
    logic              busy;
    logic              done;

    logic              start1 = 1'b0;
    logic [ACC-1:0]    acc1 = '0;
    logic [SW-1:0]     shift1 = '0;
    logic              busy1;
    logic              done1;

    mac_drain_if #(.OUTPUT_DATA_WIDTH(OW)) bus ();
    mac_drain_if #(.OUTPUT_DATA_WIDTH(OW)) bus1 ();

    mac_drain #(.NUM_MACS(N), .ACCUMULATOR_DATA_WIDTH(ACC), .OUTPUT_DATA_WIDTH(OW), .SHIFT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_in(acc_in), .shift(shift),
        .out_if(bus), .busy(busy), .done(done)
    );

    mac_drain #(.NUM_MACS(1), .ACCUMULATOR_DATA_WIDTH(ACC), .OUTPUT_DATA_WIDTH(OW), .SHIFT_WIDTH(SW)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .acc_in(acc1), .shift(shift1),
        .out_if(bus1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t e_item;
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;
    int   phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference requantizer straight from the arithmetic definition.
    function automatic logic [OW-1:0] ref_requant(input longint unsigned acc, input int unsigned s);
        longint unsigned r;
        longint unsigned cap;
        cap = (64'd1 << OW) - 1;
        if (s == 0)        r = acc;
        else if (s > ACC)  r = 0;
        else               r = (acc + (64'd1 << (s - 1))) >> s;
        return (r > cap) ? OW'(cap) : OW'(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_drain(input logic [N*ACC-1:0] accs, input logic [SW-1:0] s);
        acc_in = accs;
        shift  = s;
        start  = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back('{ref_requant(longint'(accs[i*ACC +: ACC]), int'(s)), (i == N - 1)});
        end
        step();
        start  = 1'b0;
        acc_in = {$urandom, $urandom};
        shift  = SW'($urandom);
        check("valid_after_start", bus.out_valid, 1);
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            acc_in = {$urandom, $urandom};
            step();
            cycles++;
        end
        check("done_seen", done, 1);
        check("busy_low_with_done", busy, 0);
    endtask

    // out_ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        bus.out_ready  = 1'b1;
        bus1.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            phase++;
        end
    end

    logic          done_due = 1'b0;
    logic          stall_prev = 1'b0;
    logic [OW-1:0] held_data;
    logic          held_last;

    always @(negedge clk) begin
        if (rst) begin
            done_due   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("done_pulse", done, done_due);
            check("busy_matches_valid", busy, bus.out_valid);
            done_due = 1'b0;
            if (stall_prev) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, held_data);
                check("stall_last", bus.out_last, held_last);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held_data  = bus.out_data;
            held_last  = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_element: got data %0h with no element expected at %0t", bus.out_data, $time);
                end else begin
                    e_item = exp_q.pop_front();
                    check("out_data", bus.out_data, e_item.data);
                    check("out_last", bus.out_last, e_item.last);
                    if (e_item.last) done_due = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [N*ACC-1:0] accs;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_valid", bus.out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_last", bus.out_last, 0);
        check("reset_data", bus.out_data, 0);
        check("reset_last_n1", bus1.out_last, 0);

        // Rounding and saturation, full-rate drain with exact latency.
        ready_mode = 0;
        start_drain({16'h0000, 16'h0040, 16'h0006, 16'h0005}, 4'd2);
        wait_done(50, cyc);
        check("drain_latency", cyc, N);

        // Zero shift, then all-ones input and large shift.
        start_drain({16'd16, 16'd15, 16'd20, 16'd9}, 4'd0);
        wait_done(50, cyc);
        start_drain({N{16'hFFFF}}, 4'd4);
        wait_done(50, cyc);
        start_drain({N{16'h7FFF}}, 4'd15);
        wait_done(50, cyc);

        // Backpressure with inputs changing underneath the drain.
        ready_mode = 1;
        start_drain({16'h1234, 16'h0F0F, 16'h00FF, 16'h0033}, 4'd3);
        wait_done(100, cyc);

        // Start pulses during SEND are ignored; start in the done cycle is accepted.
        start_drain({16'h0010, 16'h0020, 16'h0030, 16'h0040}, 4'd2);
        for (int k = 0; k < 3; k++) begin
            start  = 1'b1;
            acc_in = {$urandom, $urandom};
            step();
            start  = 1'b0;
            step();
        end
        wait_done(100, cyc);
        start_drain({16'h0003, 16'h0007, 16'h000B, 16'h000D}, 4'd1);
        wait_done(100, cyc);

        // Reset mid-drain after two transfers.
        ready_mode = 0;
        start_drain({16'h0011, 16'h0022, 16'h0033, 16'h0044}, 4'd0);
        step();
        step();
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        check("midreset_valid", bus.out_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_data", bus.out_data, 0);
        for (int k = 0; k < 5; k++) step();
        start_drain({16'h0001, 16'h0002, 16'h0003, 16'h0004}, 4'd0);
        wait_done(50, cyc);

        // Single-element configuration.
        acc1   = 16'h0011;
        shift1 = 4'd1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("n1_valid", bus1.out_valid, 1);
        check("n1_last", bus1.out_last, 1);
        check("n1_data", bus1.out_data, ref_requant(64'h11, 1));
        step();
        check("n1_done", done1, 1);
        check("n1_idle", bus1.out_valid, 0);

        // Randomized drains under random backpressure.
        ready_mode = 2;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                accs[i*ACC +: ACC] = ACC'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            end
            start_drain(accs, SW'($urandom_range(0, 15)));
            wait_done(200, cyc);
        end

        ready_mode = 0;
        for (int k = 0; k < 3; k++) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
